// File: rtl/lc3_pkg.sv
// Shared LC-3 datapath types and constants.
package lc3_pkg;

  typedef logic [2:0]  reg_idx_t;
  typedef logic [15:0] word_t;

  localparam reg_idx_t   R7_IDX    = 3'b111;
  localparam logic [2:0] NZP_N     = 3'b100;
  localparam logic [2:0] NZP_Z     = 3'b010;
  localparam logic [2:0] NZP_P     = 3'b001;
  localparam logic [2:0] NZP_RESET = NZP_Z;

endpackage

// File: rtl/nzp_gen.sv
// Combinational bus -> one-hot {N,Z,P} condition-code encoding.
module nzp_gen
  import lc3_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] bus,
  output logic [2:0]       nzp
);

  // Sign bit wins, then zero test, otherwise positive.
  always_comb begin
    nzp = NZP_P;
    if (bus[WIDTH-1]) begin
      nzp = NZP_N;
    end else if (bus == '0) begin
      nzp = NZP_Z;
    end
  end

endmodule

// File: rtl/reg_file_cc.sv
// LC-3 general register file (R0-R7) with NZP condition codes and BEN flop.
// Optional build macro REGFILE_BYPASS_EN: forwards BUS to a read port whose
// index matches the register being written in the same cycle.
module reg_file_cc
  import lc3_pkg::*;
#(
  parameter int unsigned NREGS = 8,
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LD_REG,
  input  logic             LD_CC,
  input  logic             LD_BEN,
  input  logic             DRMUX,
  input  logic             SR1MUX,
  input  logic [15:0]      IR,
  input  logic [WIDTH-1:0] BUS,
  output logic [WIDTH-1:0] SR1_OUT,
  output logic [WIDTH-1:0] SR2_OUT,
  output logic [2:0]       NZP,
  output logic             BEN
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [2:0]       nzp_q;
  logic             ben_q;

  reg_idx_t   dr;
  reg_idx_t   sr1;
  reg_idx_t   sr2;
  logic [2:0] cc_next;

  // Opcode and immediate fields not used by the register file.
  logic unused_ir;
  assign unused_ir = ^{IR[15:12], IR[5:3]};

  // Register index selection from IR fields.
  always_comb begin
    dr  = DRMUX ? R7_IDX : IR[11:9];
    sr1 = SR1MUX ? IR[8:6] : IR[11:9];
    sr2 = IR[2:0];
  end

  nzp_gen #(
    .WIDTH (WIDTH)
  ) u_nzp_gen (
    .bus (BUS),
    .nzp (cc_next)
  );

  // State update: reset dominates every load; loads are independent.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      nzp_q <= NZP_RESET;
      ben_q <= 1'b0;
    end else begin
      if (LD_REG) begin
        regs_q[dr] <= BUS;
      end
      if (LD_CC) begin
        nzp_q <= cc_next;
      end
      // Uses the pre-edge NZP even when LD_CC fires on the same edge.
      if (LD_BEN) begin
        ben_q <= |(IR[11:9] & nzp_q);
      end
    end
  end

  // Combinational read ports, optionally forwarding the in-flight write.
  always_comb begin
    SR1_OUT = regs_q[sr1];
    SR2_OUT = regs_q[sr2];
`ifdef REGFILE_BYPASS_EN
    if (LD_REG && (dr == sr1)) begin
      SR1_OUT = BUS;
    end
    if (LD_REG && (dr == sr2)) begin
      SR2_OUT = BUS;
    end
`else
`endif
  end

  assign NZP = nzp_q;
  assign BEN = ben_q;

endmodule

// File: tb/tb_reg_file_cc.sv
// Self-checking bench for reg_file_cc: vector table + expected-result queue.
module tb_reg_file_cc;

  logic        Clk;
  logic        Reset;
  logic        LD_REG;
  logic        LD_CC;
  logic        LD_BEN;
  logic        DRMUX;
  logic        SR1MUX;
  logic [15:0] IR;
  logic [15:0] BUS;
  logic [15:0] SR1_OUT;
  logic [15:0] SR2_OUT;
  logic [2:0]  NZP;
  logic        BEN;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_cc #(
    .NREGS (8),
    .WIDTH (16)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .LD_REG  (LD_REG),
    .LD_CC   (LD_CC),
    .LD_BEN  (LD_BEN),
    .DRMUX   (DRMUX),
    .SR1MUX  (SR1MUX),
    .IR      (IR),
    .BUS     (BUS),
    .SR1_OUT (SR1_OUT),
    .SR2_OUT (SR2_OUT),
    .NZP     (NZP),
    .BEN     (BEN)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        reset;
    logic        ld_reg;
    logic        ld_cc;
    logic        ld_ben;
    logic        drmux;
    logic        sr1mux;
    logic [15:0] ir;
    logic [15:0] bus;
    logic [15:0] exp_sr1;
    logic [15:0] exp_sr2;
    logic [2:0]  exp_nzp;
    logic        exp_ben;
  } vec_t;

  typedef struct {
    logic [15:0] sr1;
    logic [15:0] sr2;
    logic [2:0]  nzp;
    logic        ben;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[15];

  function automatic logic [15:0] mkir(input logic [2:0] f11, input logic [2:0] f8,
                                       input logic [2:0] f2);
    return {4'b0000, f11, f8, 3'b000, f2};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic rst, input logic ldr, input logic ldc, input logic ldb,
                       input logic drm, input logic s1m, input logic [15:0] ir,
                       input logic [15:0] bus);
    Reset  = rst;
    LD_REG = ldr;
    LD_CC  = ldc;
    LD_BEN = ldb;
    DRMUX  = drm;
    SR1MUX = s1m;
    IR     = ir;
    BUS    = bus;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IR, BUS);
  endtask

  // Apply one vector for one edge; expectation queued at drive, compared after the edge.
  task automatic apply(input int idx);
    exp_t e;
    exp_t got;
    vec_t v;
    v = vecs[idx];
    @(negedge Clk);
    drive(v.reset, v.ld_reg, v.ld_cc, v.ld_ben, v.drmux, v.sr1mux, v.ir, v.bus);
    e.sr1 = v.exp_sr1;
    e.sr2 = v.exp_sr2;
    e.nzp = v.exp_nzp;
    e.ben = v.exp_ben;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: queue empty at vector %0d", idx);
    end else begin
      got = exp_q.pop_front();
      check($sformatf("vec%0d sr1", idx), SR1_OUT, got.sr1);
      check($sformatf("vec%0d sr2", idx), SR2_OUT, got.sr2);
      check($sformatf("vec%0d nzp", idx), {13'b0, NZP}, {13'b0, got.nzp});
      check($sformatf("vec%0d ben", idx), {15'b0, BEN}, {15'b0, got.ben});
    end
  endtask

  initial begin
    logic [15:0] same_cycle_exp;

    // Expected values are post-edge reads with the vector's inputs still applied.
    //            rst   ldr   ldc   ldb   drm   s1m   ir                  bus       sr1      sr2      nzp     ben
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mkir(0, 0, 0), 16'h0000, 16'h0000, 16'h0000, 3'b010, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mkir(3, 0, 3), 16'hBEEF, 16'hBEEF, 16'hBEEF, 3'b010, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, mkir(2, 7, 2), 16'h3001, 16'h3001, 16'h0000, 3'b010, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mkir(3, 7, 2), 16'h8000, 16'hBEEF, 16'h0000, 3'b100, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mkir(3, 7, 2), 16'h0000, 16'hBEEF, 16'h0000, 3'b010, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mkir(7, 0, 7), 16'h0001, 16'h3001, 16'h3001, 3'b001, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mkir(1, 0, 0), 16'h0000, 16'h0000, 16'h0000, 3'b001, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mkir(6, 0, 0), 16'h0000, 16'h0000, 16'h0000, 3'b001, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mkir(1, 0, 0), 16'h0000, 16'h0000, 16'h0000, 3'b001, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, mkir(2, 0, 0), 16'h0000, 16'h0000, 16'h0000, 3'b010, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mkir(4, 0, 4), 16'h8123, 16'h8123, 16'h8123, 3'b100, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mkir(4, 0, 3), 16'h0000, 16'h8123, 16'hBEEF, 3'b100, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mkir(4, 0, 7), 16'h0000, 16'h8123, 16'h3001, 3'b100, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mkir(5, 0, 5), 16'h1234, 16'h0000, 16'h0000, 3'b010, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mkir(3, 7, 4), 16'h0000, 16'h0000, 16'h0000, 3'b010, 1'b0};

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge Clk);
    #1;

    // Random writes to every register, NZP=N and BEN=1, then a single reset edge.
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mkir(3'(i), 0, 0), 16'($urandom) | 16'h0001);
    end
    @(negedge Clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mkir(7, 0, 0), 16'h8000);
    @(negedge Clk);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mkir(7, 0, 0), 16'h0000);
    @(negedge Clk);
    idle();
    check("pre-reset ben", {15'b0, BEN}, 16'h0001);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mkir(7, 0, 0), 16'h0000);
    @(negedge Clk);
    idle();
    check("reset nzp", {13'b0, NZP}, 16'h0002);
    check("reset ben", {15'b0, BEN}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      IR = {4'b0000, 3'b000, 3'(i), 3'b000, 3'(i)};
      SR1MUX = 1'b1;
      #1;
      check($sformatf("reset sweep sr1 R%0d", i), SR1_OUT, 16'h0000);
      check($sformatf("reset sweep sr2 R%0d", i), SR2_OUT, 16'h0000);
    end

    // Same-cycle read of the register being written.
`ifdef REGFILE_BYPASS_EN
    same_cycle_exp = 16'hBEEF;
`else
    same_cycle_exp = 16'h0000;
`endif
    @(negedge Clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mkir(3, 0, 3), 16'hBEEF);
    #1;
    check("same-cycle sr1 R3", SR1_OUT, same_cycle_exp);
    check("same-cycle sr2 R3", SR2_OUT, same_cycle_exp);
    @(posedge Clk);
    #1;
    check("post-write sr1 R3", SR1_OUT, 16'hBEEF);
    @(negedge Clk);
    idle();

    for (int i = 0; i < 15; i++) begin
      apply(i);
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_cc.md
Name: reg_file_cc

Overview:
- Upstream neighbour of the SR2 operand mux in the LC-3 datapath.
- Holds the eight 16-bit general registers R0-R7, selects destination and source registers from IR fields, and drives SR1_OUT and SR2_OUT.
  - SR1_OUT goes to the ALU A input and ADDR1MUX.
  - SR2_OUT goes to the SR2 operand mux.
- Also owns the NZP condition-code register and the BEN branch-enable flop, both loaded from the shared 16-bit bus under control-FSM command.

Parameters:
- NREGS, 8, number of general registers (power of two; LC-3 fixes 8).
- WIDTH, 16, datapath width.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- LD_REG  input  1  write BUS into the destination register this edge.
- LD_CC  input  1  load NZP from BUS this edge.
- LD_BEN  input  1  load BEN from IR[11:9] and NZP this edge.
- DRMUX  input  1  0: DR=IR[11:9]; 1: DR=3'b111 (R7, for JSR/TRAP linkage).
- SR1MUX  input  1  0: SR1=IR[11:9]; 1: SR1=IR[8:6].
- IR  input  16  current instruction register contents.
- BUS  input  16  shared datapath bus (write data and CC source).
- SR1_OUT  output  16  combinational read of R[SR1].
- SR2_OUT  output  16  combinational read of R[IR[2:0]].
- NZP  output  3  registered condition codes {N,Z,P}.
- BEN  output  1  registered branch enable.

Behaviour:
- Reset:
  - Synchronous; has priority over every load.
  - On the next rising edge with Reset=1: R0-R7 <= 16'h0000, NZP <= 3'b010 (Z, consistent with zeroed registers), BEN <= 0.
  - Reset arriving mid-instruction discards any concurrent LD_REG, LD_CC or LD_BEN.
- Reads:
  - Purely combinational, zero latency.
  - SR1_OUT = R[SR1], SR2_OUT = R[IR[2:0]].
  - Both ports may address the same register.
- Register write:
  - On an edge with LD_REG=1, R[DR] <= BUS.
  - A read of R[DR] in the same cycle returns the old value; the new value is visible the cycle after the edge (see the optional feature for the exception).
- Condition codes (on an edge with LD_CC=1):
  - BUS[15]=1 -> NZP <= 3'b100.
  - BUS==16'h0000 -> NZP <= 3'b010.
  - Otherwise -> NZP <= 3'b001.
  - Exactly one bit is set after any load.
- BEN (on an edge with LD_BEN=1):
  - BEN <= |(IR[11:9] & NZP), using the registered NZP value present before the edge.
  - If LD_CC and LD_BEN are asserted together, BEN uses the old NZP. The FSM never does this, but the behaviour is fixed as stated.
- LD_REG and LD_CC together: both occur from the same BUS value; the two are independent.
- Holds: with no load strobe and no Reset, all state holds indefinitely.
- No X propagation: all selects are 1-bit, so every encoding is defined.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- When defined:
  - Write-through forwarding: if LD_REG=1 and DR equals the SR1 (or SR2) index, SR1_OUT (or SR2_OUT) = BUS in that same cycle.
  - This adds a combinational BUS -> SRx_OUT path.
- When undefined:
  - No forwarding; reads always return stored contents, as described above.
- Register storage, NZP and BEN behaviour are identical either way.

Decomposition:
- Shared package lc3_pkg:
  - typedef reg_idx_t (logic [2:0]), typedef word_t (logic [15:0]).
  - Constants R7_IDX = 3'b111, NZP_N = 3'b100, NZP_Z = 3'b010, NZP_P = 3'b001, NZP_RESET = NZP_Z.
- One sub-module: nzp_gen.
  - Combinational BUS -> 3-bit NZP encoding.
  - Reused by reg_file_cc and by any later CC-sourcing block.

Test Plan:
1. Reset=1 one edge after random writes -> all registers read 16'h0000 via SR1/SR2 sweep; NZP=3'b010; BEN=0.
2. LD_REG=1, DRMUX=0, IR[11:9]=3, BUS=16'hBEEF -> R3=16'hBEEF next cycle. Same-cycle SR1 read of R3 returns old value with REGFILE_BYPASS_EN undefined and 16'hBEEF with it defined.
3. DRMUX=1, LD_REG=1, BUS=16'h3001 -> R7=16'h3001; IR[11:9]=2 register unchanged.
4. LD_CC with BUS=16'h8000 -> NZP=100; BUS=16'h0000 -> 010; BUS=16'h0001 -> 001.
5. NZP=001; LD_BEN with IR[11:9]=3'b001 -> BEN=1; with IR[11:9]=3'b110 -> BEN=0. LD_CC (BUS=0) and LD_BEN (IR[11:9]=010) together -> BEN=0 (old NZP), NZP=010.
6. Reset=1 asserted with LD_REG=1, BUS=16'h1234, DR=5 -> R5=0, Reset wins.
